// File: rtl/tt_io_pkg.sv
// Constants shared by the tile's input-conditioning stage, the logic core and the top wrapper.
package tt_io_pkg;

    localparam int IO_WIDTH                = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int DEBOUNCE_CYCLES_MIN     = 2;
    localparam int DEBOUNCE_CYCLES_MAX     = 65535;

    function automatic bit debounce_cycles_legal(input int cycles);
        return (cycles >= DEBOUNCE_CYCLES_MIN) && (cycles <= DEBOUNCE_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/io_debounce_if.sv
// Pad-side inputs and conditioned outputs of io_debounce, grouped as one bundle.
interface io_debounce_if #(
    parameter int WIDTH = tt_io_pkg::IO_WIDTH
);

    logic             ena;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output ena, raw_in,
        input  clean_out, rise, fall, changed
    );

    modport slave (
        input  ena, raw_in,
        output clean_out, rise, fall, changed
    );

endinterface

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, stability counter, accepted level and edge pulses.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic pulse_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // With ena low the counter and level freeze so counting resumes where it left off.
        if (ena) begin
            if (s2_q == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                clean_d = s2_q;
                cnt_d   = '0;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean     = clean_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign pulse_nxt = rise_d | fall_d;

endmodule

// File: rtl/io_debounce.sv
// Synchronizes and debounces the tile's pad inputs; emits per-bit rise/fall pulses and a summary
// changed flag, all registered.
module io_debounce
    import tt_io_pkg::*;
#(
    parameter int WIDTH           = IO_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    io_debounce_if.slave  bus
);

    if (!debounce_cycles_legal(DEBOUNCE_CYCLES)) begin : g_bad_cycles
        $error("io_debounce: DEBOUNCE_CYCLES must be in 2..65535");
    end
    if (CNT_W != $clog2(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("io_debounce: CNT_W is derived and must not be overridden");
    end

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] pulse_nxt_w;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .ena       (bus.ena),
            .raw       (bus.raw_in[i]),
            .clean     (clean_w[i]),
            .rise      (rise_w[i]),
            .fall      (fall_w[i]),
            .pulse_nxt (pulse_nxt_w[i])
        );
    end

    // Built from the bits' next-pulse terms so changed lands in the same cycle as rise/fall.
    always_comb begin
        changed_d = |pulse_nxt_w;
    end

    always_ff @(posedge clk) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= changed_d;
    end

    assign bus.clean_out = clean_w;
    assign bus.rise      = rise_w;
    assign bus.fall      = fall_w;
    assign bus.changed   = changed_q;

endmodule
